// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
// Shared Y86-64 definitions used by the write-back scheduler and its decoder.
//   - icode constants I_HALT .. I_POPQ
//   - register specifiers R_RSP (stack pointer) and R_NONE (no register)
//   - DEF_REG_W: default register data width
//   - scheduler state and write-data select enumerations
//   - reg_valid(): true when a register specifier names a real register
// -----------------------------------------------------------------------------
package y86_pkg;

  localparam int DEF_REG_W = 64;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] R_RSP  = 4'h4;
  localparam logic [3:0] R_NONE = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } wb_state_e;

  typedef enum logic {
    SEL_VALE = 1'b0,
    SEL_VALM = 1'b1
  } wb_sel_e;

  function automatic logic reg_valid(input logic [3:0] r);
    return (r != R_NONE);
  endfunction

endpackage

// File: rtl/wb_decode.sv
// -----------------------------------------------------------------------------
// wb_decode
// Combinational write-list decoder for one retiring Y86-64 instruction.
// Produces up to two register writes: the first (we0/addr0, data chosen by
// sel0) and an optional second write (we1/addr1) whose data is always valM.
// Writes addressed to R_NONE are already suppressed here.
// Ports:
//   icode  in  4  instruction code
//   cnd    in  1  condition result (cmovxx only)
//   ra, rb in  4  register specifiers
//   we0    out 1  first write enable
//   addr0  out 4  first write register
//   sel0   out    first write data select (valE / valM)
//   we1    out 1  second write enable (popq only)
//   addr1  out 4  second write register
// -----------------------------------------------------------------------------
module wb_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic       cnd,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  output logic       we0,
  output logic [3:0] addr0,
  output wb_sel_e    sel0,
  output logic       we1,
  output logic [3:0] addr1
);

  // Decode the write list from the instruction code.
  always_comb begin
    we0   = 1'b0;
    addr0 = 4'h0;
    sel0  = SEL_VALE;
    we1   = 1'b0;
    addr1 = 4'h0;
    case (icode)
      I_CMOVXX: begin
        addr0 = rb;
        if (cnd) begin
          we0 = reg_valid(rb);
        end else begin
          we0 = 1'b0;
        end
      end
      I_IRMOVQ, I_OPQ: begin
        addr0 = rb;
        we0   = reg_valid(rb);
      end
      I_MRMOVQ: begin
        addr0 = ra;
        sel0  = SEL_VALM;
        we0   = reg_valid(ra);
      end
      I_CALL, I_RET, I_PUSHQ: begin
        addr0 = R_RSP;
        we0   = 1'b1;
      end
      // rsp update goes first so that popq %rsp leaves rsp = valM.
      I_POPQ: begin
        addr0 = R_RSP;
        we0   = 1'b1;
        addr1 = ra;
        we1   = reg_valid(ra);
      end
      default: begin
        we0   = 1'b0;
        addr0 = 4'h0;
        sel0  = SEL_VALE;
        we1   = 1'b0;
        addr1 = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/wb_scheduler.sv
// -----------------------------------------------------------------------------
// wb_scheduler
// Sequences Y86-64 write-back traffic onto the register file's single write
// port. Accepts one retiring instruction per handshake and emits one
// registered register write per cycle; popq is split over two cycles
// (rsp <= valE, then rA <= valM).
// Optional feature macro: WB_HOST_PORT_EN adds a debug host write port that
// is served only in idle cycles with no pipeline request.
// Ports:
//   clk, reset          clock / synchronous active-high reset
//   req_valid/req_ready retire handshake (req_ready depends on state only)
//   req_icode, req_cnd, req_rA, req_rB, req_valE, req_valM  instruction data
//   rf_we, rf_waddr, rf_wdata  registered register-file write port
//   retired             accepted-instruction counter (wraps)
//   host_valid/host_ready/host_addr/host_data  debug write port (macro only)
// -----------------------------------------------------------------------------
module wb_scheduler
  import y86_pkg::*;
#(
  parameter int REG_W = DEF_REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_icode,
  input  logic             req_cnd,
  input  logic [3:0]       req_rA,
  input  logic [3:0]       req_rB,
  input  logic [REG_W-1:0] req_valE,
  input  logic [REG_W-1:0] req_valM,
`ifdef WB_HOST_PORT_EN
  input  logic             host_valid,
  output logic             host_ready,
  input  logic [3:0]       host_addr,
  input  logic [REG_W-1:0] host_data,
`endif
  output logic             rf_we,
  output logic [3:0]       rf_waddr,
  output logic [REG_W-1:0] rf_wdata,
  output logic [CNT_W-1:0] retired
);

  wb_state_e        state_r, state_s;
  logic             rf_we_r, rf_we_s;
  logic [3:0]       rf_waddr_r, rf_waddr_s;
  logic [REG_W-1:0] rf_wdata_r, rf_wdata_s;
  logic [3:0]       pend_addr_r, pend_addr_s;
  logic [REG_W-1:0] pend_data_r, pend_data_s;
  logic [CNT_W-1:0] retired_r, retired_s;

  logic             dec_we0_s;
  logic [3:0]       dec_addr0_s;
  wb_sel_e          dec_sel0_s;
  logic             dec_we1_s;
  logic [3:0]       dec_addr1_s;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  wb_decode u_decode (
    .icode (req_icode),
    .cnd   (req_cnd),
    .ra    (req_rA),
    .rb    (req_rB),
    .we0   (dec_we0_s),
    .addr0 (dec_addr0_s),
    .sel0  (dec_sel0_s),
    .we1   (dec_we1_s),
    .addr1 (dec_addr1_s)
  );

  assign req_ready = (state_r == ST_IDLE);

`ifdef WB_HOST_PORT_EN
  // Pipeline has priority: the host is only served when no request is offered.
  assign host_ready = (state_r == ST_IDLE) && !req_valid && !reset;
`endif

  assign rf_we    = rf_we_r;
  assign rf_waddr = rf_waddr_r;
  assign rf_wdata = rf_wdata_r;
  assign retired  = retired_r;

  // Next-state, next write and counter logic.
  always_comb begin
    state_s     = state_r;
    rf_we_s     = 1'b0;
    rf_waddr_s  = rf_waddr_r;
    rf_wdata_s  = rf_wdata_r;
    pend_addr_s = pend_addr_r;
    pend_data_s = pend_data_r;
    retired_s   = retired_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          retired_s = retired_r + CNT_ONE;
          if (dec_we0_s) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = dec_addr0_s;
            if (dec_sel0_s == SEL_VALM) begin
              rf_wdata_s = req_valM;
            end else begin
              rf_wdata_s = req_valE;
            end
          end else begin
            rf_we_s = 1'b0;
          end
          if (dec_we1_s) begin
            pend_addr_s = dec_addr1_s;
            pend_data_s = req_valM;
            state_s     = ST_PEND;
          end else begin
            state_s = ST_IDLE;
          end
        end
`ifdef WB_HOST_PORT_EN
        else if (host_valid) begin
          if (reg_valid(host_addr)) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = host_addr;
            rf_wdata_s = host_data;
          end else begin
            rf_we_s = 1'b0;
          end
        end
`endif
        else begin
          rf_we_s = 1'b0;
        end
      end
      ST_PEND: begin
        rf_we_s    = 1'b1;
        rf_waddr_s = pend_addr_r;
        rf_wdata_s = pend_data_r;
        state_s    = ST_IDLE;
      end
      default: begin
        rf_we_s = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, output and counter registers; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      rf_we_r     <= 1'b0;
      rf_waddr_r  <= 4'h0;
      rf_wdata_r  <= {REG_W{1'b0}};
      pend_addr_r <= 4'h0;
      pend_data_r <= {REG_W{1'b0}};
      retired_r   <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      rf_we_r     <= rf_we_s;
      rf_waddr_r  <= rf_waddr_s;
      rf_wdata_r  <= rf_wdata_s;
      pend_addr_r <= pend_addr_s;
      pend_data_r <= pend_data_s;
      retired_r   <= retired_s;
    end
  end

endmodule

// File: tb/tb_wb_scheduler.sv
module tb_wb_scheduler;

  localparam int REG_W = 64;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [3:0]       req_icode = 4'h0;
  logic             req_cnd = 1'b0;
  logic [3:0]       req_rA = 4'hF;
  logic [3:0]       req_rB = 4'hF;
  logic [REG_W-1:0] req_valE = '0;
  logic [REG_W-1:0] req_valM = '0;
  logic             rf_we;
  logic [3:0]       rf_waddr;
  logic [REG_W-1:0] rf_wdata;
  logic [CNT_W-1:0] retired;
`ifdef WB_HOST_PORT_EN
  logic             host_valid = 1'b0;
  logic             host_ready;
  logic [3:0]       host_addr = 4'h0;
  logic [REG_W-1:0] host_data = '0;
`endif

  typedef struct packed {
    logic [3:0]       a;
    logic [REG_W-1:0] d;
  } wr_t;

  wr_t              exp_q[$];
  int               vectors = 0;
  int               miscompares = 0;
  logic [CNT_W-1:0] exp_retired = '0;

  wb_scheduler #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_icode (req_icode),
    .req_cnd   (req_cnd),
    .req_rA    (req_rA),
    .req_rB    (req_rB),
    .req_valE  (req_valE),
    .req_valM  (req_valM),
`ifdef WB_HOST_PORT_EN
    .host_valid(host_valid),
    .host_ready(host_ready),
    .host_addr (host_addr),
    .host_data (host_data),
`endif
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // Reference write list for one accepted instruction, in issue order.
  function automatic void model_push(input logic [3:0] ic, input logic cnd,
                                     input logic [3:0] ra, input logic [3:0] rb,
                                     input logic [REG_W-1:0] ve, input logic [REG_W-1:0] vm);
    case (ic)
      4'h2: if (cnd && rb != 4'hF) exp_q.push_back('{rb, ve});
      4'h3, 4'h6: if (rb != 4'hF) exp_q.push_back('{rb, ve});
      4'h5: if (ra != 4'hF) exp_q.push_back('{ra, vm});
      4'h8, 4'h9, 4'hA: exp_q.push_back('{4'h4, ve});
      4'hB: begin
        exp_q.push_back('{4'h4, ve});
        if (ra != 4'hF) exp_q.push_back('{ra, vm});
      end
      default: ;
    endcase
  endfunction

  // Scoreboard: every register-file write must match the next expected one.
  always @(negedge clk) begin
    wr_t e;
    if (!reset && rf_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got r%0h=%h, no write expected", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== {e.a, e.d}) begin
          miscompares++;
          $display("FAIL write_data: got r%0h=%h, want r%0h=%h", rf_waddr, rf_wdata, e.a, e.d);
        end
      end
    end
  end

  // Offer one request (called just after a negedge); returns at the negedge
  // following its acceptance with req_valid dropped. waits = stall cycles.
  task automatic send(input logic [3:0] ic, input logic cnd, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [REG_W-1:0] ve,
                      input logic [REG_W-1:0] vm, output int waits);
    req_icode = ic; req_cnd = cnd; req_rA = ra; req_rB = rb;
    req_valE = ve; req_valM = vm; req_valid = 1'b1;
    waits = 0;
    while (req_ready !== 1'b1 && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    if (req_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, want 1", req_ready, waits);
      req_valid = 1'b0;
    end else begin
      model_push(ic, cnd, ra, rb, ve, vm);
      exp_retired = exp_retired + 16'd1;
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata, retired, req_ready} !== {1'b0, 4'h0, 64'h0, 16'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state: got we=%b a=%h d=%h ret=%0d rdy=%b, want 0/0/0/0/1",
               rf_we, rf_waddr, rf_wdata, retired, req_ready);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_irmovq();
    int w;
    send(4'h3, 1'b0, 4'hF, 4'h2, 64'h1234, 64'h0, w);
    vectors++;
    if ({rf_we, retired} !== {1'b1, exp_retired}) begin
      miscompares++;
      $display("FAIL irmovq_latency: got we=%b retired=%0d, want we=1 retired=%0d", rf_we, retired, exp_retired);
    end
    @(negedge clk);
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 4'h2, 64'h1234}) begin
      miscompares++;
      $display("FAIL irmovq_hold: got we=%b r%0h=%h, want we=0 r2=1234", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_popq();
    int w;
    send(4'hB, 1'b0, 4'h3, 4'hF, 64'h108, 64'hAA, w);
    vectors++;
    if ({req_ready, rf_we} !== {1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL popq_pend: got ready=%b we=%b, want ready=0 we=1", req_ready, rf_we);
    end
    send(4'h3, 1'b0, 4'hF, 4'h1, 64'h7, 64'h0, w);
    vectors++;
    if (w !== 1) begin
      miscompares++;
      $display("FAIL popq_back_to_back: got %0d stall cycles, want 1", w);
    end
    @(negedge clk);
  endtask

  task automatic test_popq_rsp();
    int w;
    send(4'hB, 1'b0, 4'h4, 4'hF, 64'h108, 64'h55, w);
    @(negedge clk);
    vectors++;
    if ({rf_waddr, rf_wdata} !== {4'h4, 64'h55}) begin
      miscompares++;
      $display("FAIL popq_rsp_final: got r%0h=%h, want r4=55", rf_waddr, rf_wdata);
    end
    @(negedge clk);
  endtask

  task automatic test_no_write();
    int w;
    logic [CNT_W-1:0] r0;
    r0 = retired;
    send(4'h2, 1'b0, 4'hF, 4'h5, 64'hDEAD, 64'h0, w);
    vectors++;
    if (rf_we !== 1'b0) begin
      miscompares++;
      $display("FAIL cmov_nocnd: got we=%b, want 0", rf_we);
    end
    send(4'h7, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0, w);
    vectors++;
    if ({rf_we, retired} !== {1'b0, r0 + 16'd2}) begin
      miscompares++;
      $display("FAIL jxx_nowrite: got we=%b retired=%0d, want we=0 retired=%0d", rf_we, retired, r0 + 16'd2);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    for (int i = 0; i < 48; i++) begin
      logic [3:0] ic, ra, rb;
      ic = 4'($urandom_range(0, 15));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      send(ic, 1'($urandom_range(0, 1)), ra, rb, {$urandom, $urandom}, {$urandom, $urandom}, w);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({exp_q.size() == 0, retired} !== {1'b1, exp_retired}) begin
      miscompares++;
      $display("FAIL b2b_drain: got pending=%0d retired=%0d, want 0 and %0d", exp_q.size(), retired, exp_retired);
    end
  endtask

  task automatic test_reset_pend();
    req_icode = 4'hB; req_rA = 4'h3; req_rB = 4'hF;
    req_valE = 64'h200; req_valM = 64'hBB; req_valid = 1'b1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstpend_ready: got %b, want 1", req_ready);
    end
    exp_q.push_back('{4'h4, 64'h200});
    @(negedge clk);
    req_valid = 1'b0;
    #2 reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata, retired, req_ready} !== {1'b0, 4'h0, 64'h0, 16'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL rstpend_state: got we=%b a=%h d=%h ret=%0d rdy=%b, want 0/0/0/0/1",
               rf_we, rf_waddr, rf_wdata, retired, req_ready);
    end
    reset = 1'b0;
    exp_retired = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({exp_q.size() == 0, retired} !== {1'b1, 16'h0}) begin
      miscompares++;
      $display("FAIL rstpend_drain: got pending=%0d retired=%0d, want 0 and 0", exp_q.size(), retired);
    end
  endtask

`ifdef WB_HOST_PORT_EN
  task automatic test_host();
    int w;
    logic [CNT_W-1:0] r0;
    r0 = retired;
    host_addr = 4'h7; host_data = 64'h99; host_valid = 1'b1;
    req_valid = 1'b1;
    #1;
    vectors++;
    if (host_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL host_priority: got host_ready=%b, want 0", host_ready);
    end
    send(4'h3, 1'b0, 4'hF, 4'h6, 64'h66, 64'h0, w);
    exp_q.push_back('{4'h7, 64'h99});
    #1;
    vectors++;
    if (host_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL host_ready_idle: got %b, want 1", host_ready);
    end
    @(negedge clk);
    host_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({exp_q.size() == 0, retired} !== {1'b1, r0 + 16'd1}) begin
      miscompares++;
      $display("FAIL host_drain: got pending=%0d retired=%0d, want 0 and %0d", exp_q.size(), retired, r0 + 16'd1);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_irmovq();
    test_popq();
    test_popq_rsp();
    test_no_write();
    test_back_to_back();
`ifdef WB_HOST_PORT_EN
    test_host();
`endif
    test_reset_pend();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_scheduler.md
# wb_scheduler

Sequences Y86-64 write-back traffic onto the register file's single write port. Sits between the memory stage and the register file: accepts one retiring instruction per handshake, decodes which registers it updates, and emits one register write per cycle. Two-write instructions (popq) are split across two cycles in architecturally correct order.

## Interface
- REG_W, 64: register data width
- CNT_W, 16: width of retire counter
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  retiring instruction present
- req_ready  out  1  scheduler can accept this cycle
- req_icode  in  4  instruction code
- req_cnd  in  1  condition result (cmovxx only)
- req_rA, req_rB  in  4  register specifiers (4'hF = none)
- req_valE, req_valM  in  REG_W  execute / memory results
- rf_we  out  1  register-file write enable
- rf_waddr  out  4  write register
- rf_wdata  out  REG_W  write data
- retired  out  CNT_W  accepted-instruction count
- host_valid, host_ready, host_addr[4], host_data[REG_W]: debug write port, present only with WB_HOST_PORT_EN

## Operation
- Write list decoded at acceptance from req_icode:
  - 2 cmovxx: rB<=valE only if req_cnd
  - 3 irmovq, 6 OPq: rB<=valE
  - 5 mrmovq: rA<=valM
  - 8 call, 9 ret, A pushq: rsp(4)<=valE
  - B popq: first rsp<=valE, second rA<=valM
  - 0,1,4,7,C–F: no write
- Any write whose address is 4'hF is suppressed; popq with rA=F becomes single-write.
- popq rA=4: both writes issued; valM lands last (final rsp=valM).
- States: IDLE, PEND.
  - IDLE: req_ready=1. On accept: issue first write (or none); if second write needed latch rA/valM, go PEND.
  - PEND: req_ready=0; issue latched second write; return IDLE.
- Zero-write requests accepted in one cycle, rf_we stays 0.
- retired increments on every accept, wraps at 2^CNT_W.

## Timing
- rf_we/rf_waddr/rf_wdata are registered: valid the cycle after acceptance (latency 1); register file commits on the following edge.
- Throughput: 1 instr/cycle; popq costs 2 cycles.
- req_ready combinational from state only (no dependence on req_valid).
- Reset values: state IDLE, rf_we 0, rf_waddr 0, rf_wdata 0, retired 0, host_ready 0.
- Reset in PEND: pending write discarded; rf_we 0 in the cycle after reset.
- rf_we deasserts in any cycle with no write issued; rf_waddr/rf_wdata hold last value.

## Configuration
- WB_HOST_PORT_EN defined: host port present; host_ready = (state==IDLE) && !req_valid (pipeline priority). Host accept issues rf write host_addr<=host_data with latency 1; host_addr=F suppressed; host writes do not touch retired.
- Undefined: host ports absent; behaviour otherwise identical.

## Structure
- Shared package y86_pkg: icode constants (I_HALT..I_POPQ), R_RSP=4'h4, R_NONE=4'hF, REG_W default.
- Sub-module wb_decode: combinational icode/cnd/rA/rB -> {we0, addr0, sel0, we1, addr1}; scheduler owns state, registers, counter, arbitration.

## Test plan
- irmovq rB=2 valE=0x1234 -> next cycle rf_we=1, waddr=2, wdata=0x1234; retired=1.
- popq rA=3 valE=0x108 valM=0xAA -> cycle+1 write r4=0x108, cycle+2 write r3=0xAA; req_ready=0 during PEND; back-to-back request accepted cycle+2.
- popq rA=4 valE=0x108 valM=0x55 -> writes r4=0x108 then r4=0x55.
- cmovxx rB=5 cnd=0, then jxx -> no rf_we; retired advances by 2.
- reset asserted in PEND -> no second write, all outputs zero next cycle, retired=0.
- WB_HOST_PORT_EN: host_valid and req_valid together -> pipeline written first, host_ready=0; host write r7=0x99 issues on first idle cycle without req_valid.
